// File: rtl/dual_port_ram_pkg.sv
// Shared encodings and lane-merge helper for dual_port_ram_be.
// Words up to MAX_DW bits are supported by the helper.
package dual_port_ram_pkg;

  localparam int RD_READ_FIRST  = 0;
  localparam int RD_WRITE_FIRST = 1;
  localparam int RD_NO_CHANGE   = 2;
  localparam int MAX_DW         = 256;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  // lanes with be[lane]=1 take new_w, others keep old_w
  function automatic logic [MAX_DW-1:0] lane_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_DW-1:0] be,
    input int                lw
  );
    logic [MAX_DW-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_DW; i++) begin
      if (be[i/lw]) m[i] = new_w[i];
    end
    return m;
  endfunction

endpackage

// File: rtl/dual_port_ram_init_seq.sv
// INIT/RUN sequencer: zero-fills the array through port 1
// after reset and registers the ready flag.
module dual_port_ram_init_seq
  import dual_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int INIT_ZERO  = 1
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  ready,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  ready_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= init_we ? cnt + 1'b1 : cnt;
      ready_q <= (state_nx == ST_RUN);
    end
  end

  always_comb begin
    state_nx = state;
    init_we  = 1'b0;
    unique case (state)
      ST_INIT: begin
        init_we = resetn;
        if (&cnt) state_nx = ST_RUN;
      end
      ST_RUN: ;
    endcase
  end

  assign ready     = ready_q;
  assign init_addr = cnt;

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with lane enables and read-valid handshake.
// Define DUAL_PORT_RAM_BE_OUT_REG_EN for an extra output stage.
module dual_port_ram_be
  import dual_port_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LANE_WIDTH = 8,
  parameter int RD_MODE    = 0,
  parameter int INIT_ZERO  = 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  output logic                             ready,
  input  logic                             en1,
  input  logic                             we1,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] be1,
  input  logic [ADDR_WIDTH-1:0]            addr1,
  input  logic [DATA_WIDTH-1:0]            data1,
  output logic [DATA_WIDTH-1:0]            out1,
  output logic                             rvalid1,
  input  logic                             en2,
  input  logic                             we2,
  input  logic [DATA_WIDTH/LANE_WIDTH-1:0] be2,
  input  logic [ADDR_WIDTH-1:0]            addr2,
  input  logic [DATA_WIDTH-1:0]            data2,
  output logic [DATA_WIDTH-1:0]            out2,
  output logic                             rvalid2,
  output logic                             collision
);

  localparam int NL    = DATA_WIDTH / LANE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int LW    = LANE_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  dual_port_ram_init_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INIT_ZERO  (INIT_ZERO)
  ) u_init (
    .clk       (clk),
    .resetn    (resetn),
    .ready     (ready),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  logic acc1, acc2, wr1, wr2;
  assign acc1 = en1 && ready && resetn;
  assign acc2 = en2 && ready && resetn;
  assign wr1  = acc1 && we1;
  assign wr2  = acc2 && we2;

  // port 1 is borrowed by the zero-fill sequencer while not ready
  logic                  w1_en;
  logic [ADDR_WIDTH-1:0] w1_addr;
  logic [NL-1:0]         w1_be;
  logic [DATA_WIDTH-1:0] w1_data;
  assign w1_en   = wr1 || init_we;
  assign w1_addr = init_we ? init_addr : addr1;
  assign w1_be   = init_we ? '1 : be1;
  assign w1_data = init_we ? '0 : data1;

  // port 1 lanes applied last so they win on shared lanes
  always_ff @(posedge clk) begin
    for (int l = 0; l < NL; l++) begin
      if (wr2 && be2[l])
        mem[addr2][l*LW +: LW] <= data2[l*LW +: LW];
    end
    for (int l = 0; l < NL; l++) begin
      if (w1_en && w1_be[l])
        mem[w1_addr][l*LW +: LW] <= w1_data[l*LW +: LW];
    end
  end

  logic [DATA_WIDTH-1:0] rd1, rd2, mg1, mg2;
  assign rd1 = mem[addr1];
  assign rd2 = mem[addr2];
  assign mg1 = DATA_WIDTH'(lane_merge(
    MAX_DW'(rd1), MAX_DW'(data1), MAX_DW'(be1), LW));
  assign mg2 = DATA_WIDTH'(lane_merge(
    MAX_DW'(rd2), MAX_DW'(data2), MAX_DW'(be2), LW));

  logic                  nc1, nc2;
  assign nc1 = we1 && (RD_MODE == RD_NO_CHANGE);
  assign nc2 = we2 && (RD_MODE == RD_NO_CHANGE);

  logic [DATA_WIDTH-1:0] q1, q2;
  logic                  v1, v2, c1;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q1 <= '0;
      q2 <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      c1 <= 1'b0;
    end else begin
      v1 <= acc1 && !nc1;
      v2 <= acc2 && !nc2;
      c1 <= wr1 && wr2 && (addr1 == addr2);
      if (acc1 && !nc1)
        q1 <= (we1 && RD_MODE == RD_WRITE_FIRST) ? mg1 : rd1;
      if (acc2 && !nc2)
        q2 <= (we2 && RD_MODE == RD_WRITE_FIRST) ? mg2 : rd2;
    end
  end

`ifdef DUAL_PORT_RAM_BE_OUT_REG_EN
  logic [DATA_WIDTH-1:0] q1_r, q2_r;
  logic                  v1_r, v2_r, c1_r;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q1_r <= '0;
      q2_r <= '0;
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      c1_r <= 1'b0;
    end else begin
      q1_r <= q1;
      q2_r <= q2;
      v1_r <= v1;
      v2_r <= v2;
      c1_r <= c1;
    end
  end

  assign out1      = q1_r;
  assign out2      = q2_r;
  assign rvalid1   = v1_r;
  assign rvalid2   = v2_r;
  assign collision = c1_r;
`else
  assign out1      = q1;
  assign out2      = q2;
  assign rvalid1   = v1;
  assign rvalid2   = v2;
  assign collision = c1;
`endif

endmodule

// File: doc/dual_port_ram_be.md
Name: dual_port_ram_be

Overview:
- True dual-port synchronous RAM for the LU8PEEng datapath, generalised from the single-width dual-port store.
- Adds per-lane byte enables, selectable read-during-write mode, deterministic write-collision arbitration and a read-valid handshake.
- Optional post-reset zero-fill sequencer gates access through a ready flag.
- Sits between PE scratch logic and operand buffers; both ports share one clock.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be an integer multiple of LANE_WIDTH.
- ADDR_WIDTH, 10, address bits; depth is exactly 2**ADDR_WIDTH words.
- LANE_WIDTH, 8, bits per byte-enable lane; NUM_LANES = DATA_WIDTH/LANE_WIDTH.
- RD_MODE, 0, same-port read-during-write: 0 READ_FIRST, 1 WRITE_FIRST, 2 NO_CHANGE.
- INIT_ZERO, 1, 1 = zero-fill the whole array after every reset; 0 = contents undefined after power-up.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- resetn  in  1  synchronous active-low reset.
- ready  out  1  high when accesses are accepted.
- en1  in  1  port 1 access request.
- we1  in  1  port 1 write qualifier.
- be1  in  NUM_LANES  port 1 lane write enables.
- addr1  in  ADDR_WIDTH  port 1 address.
- data1  in  DATA_WIDTH  port 1 write data.
- out1  out  DATA_WIDTH  port 1 read data.
- rvalid1  out  1  out1 holds data for an accepted access.
- en2, we2, be2, addr2, data2, out2, rvalid2: same as port 1, for port 2.
- collision  out  1  pulse: both ports wrote the same address.

Behaviour:
- Interface: one clock clk; reset resetn is synchronous, active-low.
- Reset, on any edge with resetn=0:
  - out1, out2 = 0; rvalid1, rvalid2, collision, ready = 0; init counter = 0.
  - In-flight pipeline stages are discarded.
  - Memory contents are untouched by reset itself.
  - Reset asserted mid-init restarts init from address 0.
- State machine, states INIT and RUN:
  - After reset: INIT if INIT_ZERO=1, else RUN.
  - INIT writes 0 to address cnt each cycle; cnt increments; the cycle that writes 2**ADDR_WIDTH-1 transitions to RUN.
  - INIT takes exactly 2**ADDR_WIDTH cycles.
  - ready is registered: 1 only in RUN. It rises on the edge entering RUN; with INIT_ZERO=0, that is the first edge after reset release.
- Accept rule: an access is accepted when en&&ready at a clock edge. Requests while ready=0 are dropped silently; the requester must hold them.
- Writes:
  - An accepted access with we=1 updates only lanes whose be bit is 1.
  - we=1 with be=0 writes nothing but is still treated as a write for RD_MODE.
- Read latency is 1 cycle: out and rvalid update on the edge after acceptance. With no accepted access, rvalid=0 and out holds its last value.
- Same-port read-during-write, by RD_MODE:
  - READ_FIRST: out = pre-write word, rvalid=1.
  - WRITE_FIRST: out = merged new word (enabled lanes new, others old), rvalid=1.
  - NO_CHANGE: out holds, rvalid=0.
- Cross-port, same address, same cycle:
  - Both write: lanes enabled on both ports take port 1 data. Lanes enabled on one port only take that port's data. collision=1 for exactly one cycle, aligned with the rvalid timing of that access.
  - One writes, the other reads: the reader gets the pre-write word; collision=0.
- Addressing: every ADDR_WIDTH-bit value maps to a distinct word. There is no extra word and no out-of-range condition.

Optional Feature:
- Macro: DUAL_PORT_RAM_BE_OUT_REG_EN.
- Defined: an extra output register stage on out1/out2 and rvalid1/rvalid2. Read latency becomes 2, collision is delayed to match, and reset clears the extra stage.
- Undefined: latency 1 as above.
- Behaviour is otherwise identical in both builds.

Decomposition:
- Package dual_port_ram_pkg holds:
  - RD_MODE encodings RD_READ_FIRST=0, RD_WRITE_FIRST=1, RD_NO_CHANGE=2.
  - State encoding ST_INIT, ST_RUN.
  - A lane-merge function (old word, new word, be -> merged word).
- One sub-module, dual_port_ram_init_seq:
  - Contains the INIT/RUN FSM, address counter and ready register.
  - Drives port-1 write overrides during INIT.

Test Plan:
- INIT_ZERO=1, ADDR_WIDTH=4: release resetn, en1=1 held -> ready=0 for exactly 16 cycles, then 1; reads of addr 0..15 return 0 with rvalid one cycle after each accept.
- Port 1 writes 0xDEADBEEF to addr 5 with be=4'b1111, then be=4'b0011 with 0x00001234 -> subsequent read returns 0xDEAD1234.
- RD_MODE=0/1/2, addr 3 holds 0x11111111, port 1 writes 0x22222222 -> out1 next cycle = 0x11111111 / 0x22222222 / unchanged with rvalid1=0.
- Both ports write addr 7 in one cycle, be1=4'b0011 data 0xAAAAAAAA, be2=4'b1110 data 0xBBBBBBBB -> word = 0xBBBBAAAA, collision high exactly 1 cycle.
- resetn pulsed low mid-INIT at cnt=9, and again during a read burst -> counter restarts at 0, rvalid cleared, pending read data never appears.
- With DUAL_PORT_RAM_BE_OUT_REG_EN defined, repeat the write/read of addr 5 -> data and rvalid appear 2 cycles after accept.
